// File: rtl/round_adder.sv
// Registered rounding incrementer for the FPU add/sub path.
// Adds the round bit to InData through a ripple chain of half-adder cells and
// registers the low WIDTH bits plus the carry-out one cycle later.
module round_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             round,
  input  logic [WIDTH-1:0] InData,
  output logic [WIDTH-1:0] RoundedData,
  output logic             Overflow,
  output logic             out_valid
);

  // carry[i] is the carry into bit i; round is the carry-in to bit 0.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign carry[0] = round;

  // Half-adder cell per bit: incrementing only ever needs a XOR c and a AND c.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]       = InData[i] ^ carry[i];
    assign carry[i + 1] = InData[i] & carry[i];
  end

  // Next-state: load a new result on in_valid, otherwise hold data and drop valid.
  always_comb begin
    data_d  = data_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = sum;
      ovf_d   = carry[WIDTH];
      valid_d = 1'b1;
    end
  end

  // Output registers with synchronous reset taking priority over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign RoundedData = data_q;
  assign Overflow    = ovf_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_round_adder.sv
// Directed self-checking bench for round_adder (WIDTH = 8).
module tb_round_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         round;
  logic [W-1:0] InData;
  logic [W-1:0] RoundedData;
  logic         Overflow;
  logic         out_valid;

  int total;
  int bad;

  round_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .round       (round),
    .InData      (InData),
    .RoundedData (RoundedData),
    .Overflow    (Overflow),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [W-1:0] d);
    in_valid = v;
    round    = r;
    InData   = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b0, 8'h00}) begin
        bad++;
        $display("FAIL reset_cycle%0d: got ovf=%b vld=%b data=%h want ovf=0 vld=0 data=00",
                 i, Overflow, out_valid, RoundedData);
      end
    end
  endtask

  task automatic test_pass_through();
    logic [W-1:0] vals [4];
    vals[0] = 8'hFF; vals[1] = 8'h00; vals[2] = 8'hA5; vals[3] = 8'h80;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      step();
      total++;
      if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, vals[i]}) begin
        bad++;
        $display("FAIL pass_%h: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=%h",
                 vals[i], Overflow, out_valid, RoundedData, vals[i]);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b1, 8'hFF);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b1, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL overflow_ff: got ovf=%b vld=%b data=%h want ovf=1 vld=1 data=00",
               Overflow, out_valid, RoundedData);
    end
    drive(1'b1, 1'b1, 8'hFE);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, 8'hFF}) begin
      bad++;
      $display("FAIL inc_fe: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=ff",
               Overflow, out_valid, RoundedData);
    end
    drive(1'b1, 1'b1, 8'h00);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, 8'h01}) begin
      bad++;
      $display("FAIL inc_00: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=01",
               Overflow, out_valid, RoundedData);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 8'h0B);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, 8'h0C}) begin
      bad++;
      $display("FAIL b2b_first: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=0c",
               Overflow, out_valid, RoundedData);
    end
    drive(1'b1, 1'b1, 8'h7F);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, 8'h80}) begin
      bad++;
      $display("FAIL b2b_second: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=80",
               Overflow, out_valid, RoundedData);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 8'h0B);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, 8'h0C}) begin
      bad++;
      $display("FAIL hold_setup: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=0c",
               Overflow, out_valid, RoundedData);
    end
    drive(1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b0, 8'h0C}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got ovf=%b vld=%b data=%h want ovf=0 vld=0 data=0c",
                 i, Overflow, out_valid, RoundedData);
      end
    end
  endtask

  // Inputs wiggled between edges must not matter; only the edge value counts.
  task automatic test_between_edges();
    drive(1'b1, 1'b0, 8'h33);
    #2 drive(1'b1, 1'b1, 8'hFF);
    #2 drive(1'b0, 1'b1, 8'h21);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b0, 8'h0C}) begin
      bad++;
      $display("FAIL glitch_hold: got ovf=%b vld=%b data=%h want ovf=0 vld=0 data=0c",
               Overflow, out_valid, RoundedData);
    end
    drive(1'b1, 1'b1, 8'hFF);
    #3 drive(1'b1, 1'b0, 8'h44);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, 8'h44}) begin
      bad++;
      $display("FAIL glitch_last: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=44",
               Overflow, out_valid, RoundedData);
    end
  endtask

  task automatic test_reset_priority();
    // Leave a non-zero overflow result in the registers first.
    drive(1'b1, 1'b1, 8'hFF);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL rst_priority: got ovf=%b vld=%b data=%h want ovf=0 vld=0 data=00",
               Overflow, out_valid, RoundedData);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL post_rst_idle: got ovf=%b vld=%b data=%h want ovf=0 vld=0 data=00",
               Overflow, out_valid, RoundedData);
    end
    drive(1'b1, 1'b1, 8'h3F);
    step();
    total++;
    if ({Overflow, out_valid, RoundedData} !== {1'b0, 1'b1, 8'h40}) begin
      bad++;
      $display("FAIL post_rst_first: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=40",
               Overflow, out_valid, RoundedData);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    test_reset();
    test_pass_through();
    test_overflow();
    test_back_to_back();
    test_hold();
    test_between_edges();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
